// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer driving PC/MAR/memory bus strobes,
// capturing the fetched word into ir, with a wait-state timeout into FAULT.
module fetch_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_ready,
    input  logic        ir_ack,
    input  logic [15:0] data,
    output logic        pc_out,
    output logic        mar_load,
    output logic        mem_read,
    output logic        pc_increment,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        busy,
    output logic        fault,
    output logic [7:0]  fetch_count
);
    typedef enum logic [2:0] {IDLE, ADDR, READ, HOLD, FAULT} state_t;
    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);
    state_t      r_state;
    logic [7:0]  r_wait;
    logic [7:0]  r_count;
    logic [15:0] r_ir;
    logic        r_pc_out;
    logic        r_mar_load;
    logic        r_mem_read;
    logic        r_busy;
    logic        r_fault;
    logic        r_ir_valid;
    // Strobes are registered alongside the state so each is a clean flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait     <= '0;
            r_count    <= '0;
            r_ir       <= '0;
            r_pc_out   <= 1'b0;
            r_mar_load <= 1'b0;
            r_mem_read <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
            r_ir_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state    <= ADDR;
                    r_pc_out   <= 1'b1;
                    r_mar_load <= 1'b1;
                    r_busy     <= 1'b1;
                end
                ADDR: begin
                    r_state    <= READ;
                    r_pc_out   <= 1'b0;
                    r_mar_load <= 1'b0;
                    r_mem_read <= 1'b1;
                    r_wait     <= '0;
                end
                READ: if (mem_ready) begin
                    r_state    <= HOLD;
                    r_mem_read <= 1'b0;
                    r_ir       <= data;
                    r_ir_valid <= 1'b1;
                    r_count    <= r_count + 8'd1;
                end else if (r_wait == LAST_WAIT) begin
                    r_state    <= FAULT;
                    r_mem_read <= 1'b0;
                    r_fault    <= 1'b1;
                end else begin
                    r_wait <= r_wait + 8'd1;
                end
                HOLD: if (ir_ack) begin
                    r_state    <= IDLE;
                    r_ir_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign pc_increment = (r_state == READ) && mem_ready;
    assign pc_out       = r_pc_out;
    assign mar_load     = r_mar_load;
    assign mem_read     = r_mem_read;
    assign ir           = r_ir;
    assign ir_valid     = r_ir_valid;
    assign busy         = r_busy;
    assign fault        = r_fault;
    assign fetch_count  = r_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl; fetched words are queued when
// presented on the bus and compared when ir_valid reports them.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_ack = 1'b0;
    logic [15:0] data = '0;
    logic        pc_out, mar_load, mem_read, pc_increment, ir_valid, busy, fault;
    logic [15:0] ir;
    logic [7:0]  fetch_count;
    logic [15:0] sb[$];
    logic [7:0]  exp_count = '0;
    int n_vec = 0;
    int n_err = 0;
    int c_pc_out = 0, c_mem_read = 0, c_pc_inc = 0;

    fetch_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .ir_ack(ir_ack),
        .data(data), .pc_out(pc_out), .mar_load(mar_load), .mem_read(mem_read),
        .pc_increment(pc_increment), .ir(ir), .ir_valid(ir_valid), .busy(busy),
        .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pc_out) c_pc_out++;
        if (mem_read) c_mem_read++;
        if (pc_increment) c_pc_inc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        c_pc_out = 0;
        c_mem_read = 0;
        c_pc_inc = 0;
    endtask

    // Drives one fetch and leaves the DUT in HOLD; the word goes to the scoreboard.
    task automatic do_fetch(input logic [15:0] d, input int waits);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_ready = 1'b0;
        repeat (waits) tick();
        mem_ready = 1'b1;
        data = d;
        sb.push_back(d);
        exp_count = exp_count + 8'd1;
        tick();
        mem_ready = 1'b0;
        data = 16'hDEAD;
    endtask

    task automatic do_ack();
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [31:0] got;
        rst = 1'b1;
        start = 1'b1;
        mem_ready = 1'b1;
        ir_ack = 1'b1;
        tick();
        tick();
        got = {ir, 8'(fetch_count), ir_valid, fault, busy, pc_out, mar_load, mem_read, 2'b00};
        n_vec++;
        if (got !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", got, 32'h0);
        end
        rst = 1'b0;
        start = 1'b0;
        mem_ready = 1'b0;
        ir_ack = 1'b0;
        exp_count = '0;
        tick();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        clr_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if ({pc_out, mar_load, mem_read, busy} !== 4'b1101) begin
            n_err++;
            $display("FAIL basic_addr_strobes: got %b expected 1101", {pc_out, mar_load, mem_read, busy});
        end
        mem_ready = 1'b1;
        data = 16'h1234;
        sb.push_back(16'h1234);
        exp_count = exp_count + 8'd1;
        tick();
        n_vec++;
        if ({pc_out, mar_load, mem_read, pc_increment} !== 4'b0011) begin
            n_err++;
            $display("FAIL basic_read_strobes: got %b expected 0011", {pc_out, mar_load, mem_read, pc_increment});
        end
        tick();
        mem_ready = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({ir, ir_valid, fetch_count} !== {e, 1'b1, exp_count}) begin
            n_err++;
            $display("FAIL basic_ir: got ir=%h v=%b cnt=%0d expected ir=%h v=1 cnt=%0d", ir, ir_valid, fetch_count, e, exp_count);
        end
        n_vec++;
        if ({c_pc_out, c_pc_inc} !== {32'd1, 32'd1}) begin
            n_err++;
            $display("FAIL basic_pulses: got pc_out=%0d pc_inc=%0d expected 1 1", c_pc_out, c_pc_inc);
        end
        do_ack();
        n_vec++;
        if ({ir_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_ack_idle: got %b expected 00", {ir_valid, busy});
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] e;
        clr_counts();
        do_fetch(16'hABCD, 3);
        e = sb.pop_front();
        n_vec++;
        if ({ir, ir_valid, fault} !== {e, 2'b10}) begin
            n_err++;
            $display("FAIL wait_ir: got ir=%h v=%b f=%b expected ir=%h v=1 f=0", ir, ir_valid, fault, e);
        end
        n_vec++;
        if ({c_mem_read, c_pc_inc} !== {32'd4, 32'd1}) begin
            n_err++;
            $display("FAIL wait_pulses: got mem_read=%0d pc_inc=%0d expected 4 1", c_mem_read, c_pc_inc);
        end
        do_ack();
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        do_fetch(16'h5A5A, 0);
        e = sb.pop_front();
        clr_counts();
        start = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({ir, ir_valid, busy, pc_out, mar_load, mem_read, pc_increment} !== {e, 6'b110000}) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got ir=%h flags=%b expected ir=%h flags=110000", i, ir, {ir_valid, busy, pc_out, mar_load, mem_read, pc_increment}, e);
            end
        end
        mem_ready = 1'b0;
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        n_vec++;
        if ({ir_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL backpressure_release: got %b expected 00", {ir_valid, busy});
        end
        tick();
        start = 1'b0;
        n_vec++;
        if ({pc_out, mar_load} !== 2'b11) begin
            n_err++;
            $display("FAIL backpressure_next_fetch: got %b expected 11", {pc_out, mar_load});
        end
        tick();
        mem_ready = 1'b1;
        data = 16'h0F0F;
        sb.push_back(16'h0F0F);
        exp_count = exp_count + 8'd1;
        tick();
        mem_ready = 1'b0;
        e = sb.pop_front();
        n_vec++;
        if ({ir, fetch_count} !== {e, exp_count}) begin
            n_err++;
            $display("FAIL backpressure_second_ir: got %h/%0d expected %h/%0d", ir, fetch_count, e, exp_count);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] e;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        do_reset();
        n_vec++;
        if ({ir, ir_valid, fault, fetch_count, busy, pc_out, mar_load, mem_read} !== 31'h0) begin
            n_err++;
            $display("FAIL midread_reset: got ir=%h v=%b f=%b cnt=%0d b=%b strobes=%b expected all zero", ir, ir_valid, fault, fetch_count, busy, {pc_out, mar_load, mem_read});
        end
        do_fetch(16'hBEEF, 1);
        e = sb.pop_front();
        n_vec++;
        if ({ir, ir_valid, fetch_count} !== {e, 1'b1, exp_count}) begin
            n_err++;
            $display("FAIL midread_refetch: got %h/%b/%0d expected %h/1/%0d", ir, ir_valid, fetch_count, e, exp_count);
        end
        do_ack();
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        logic [7:0]  c0;
        c0 = exp_count;
        for (int i = 0; i < 256; i++) begin
            do_fetch(16'($urandom), i % 3);
            e = sb.pop_front();
            n_vec++;
            if ({ir, fetch_count, fault} !== {e, exp_count, 1'b0}) begin
                n_err++;
                $display("FAIL wrap[%0d]: got ir=%h cnt=%0d f=%b expected ir=%h cnt=%0d f=0", i, ir, fetch_count, fault, e, exp_count);
            end
            do_ack();
        end
        n_vec++;
        if (fetch_count !== c0) begin
            n_err++;
            $display("FAIL wrap_final: got %0d expected %0d", fetch_count, c0);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] e;
        clr_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (14) tick();
        n_vec++;
        if ({fault, mem_read} !== 2'b01) begin
            n_err++;
            $display("FAIL timeout_early: got %b expected 01", {fault, mem_read});
        end
        tick();
        n_vec++;
        if ({fault, busy, ir_valid, mem_read} !== 4'b1100) begin
            n_err++;
            $display("FAIL timeout_fault: got %b expected 1100", {fault, busy, ir_valid, mem_read});
        end
        n_vec++;
        if ({c_pc_inc, c_mem_read} !== {32'd0, 32'd15}) begin
            n_err++;
            $display("FAIL timeout_pulses: got pc_inc=%0d mem_read=%0d expected 0 15", c_pc_inc, c_mem_read);
        end
        start = 1'b1;
        mem_ready = 1'b1;
        ir_ack = 1'b1;
        repeat (5) tick();
        n_vec++;
        if ({fault, busy, pc_out, mar_load, mem_read, c_pc_inc == 0} !== 6'b110001) begin
            n_err++;
            $display("FAIL timeout_sticky: got %b expected 110001", {fault, busy, pc_out, mar_load, mem_read, c_pc_inc == 0});
        end
        start = 1'b0;
        mem_ready = 1'b0;
        ir_ack = 1'b0;
        do_reset();
        n_vec++;
        if ({fault, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_reset: got %b expected 00", {fault, busy});
        end
        do_fetch(16'hC0DE, 0);
        e = sb.pop_front();
        n_vec++;
        if ({ir, fetch_count} !== {e, exp_count}) begin
            n_err++;
            $display("FAIL timeout_recover: got %h/%0d expected %h/%0d", ir, fetch_count, e, exp_count);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_backpressure();
        test_reset_mid_read();
        test_wrap();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, SHALL set the maximum number of READ cycles without mem_ready before a fetch fault; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 start  input  1  SHALL request one instruction fetch; sampled in IDLE only.
REQ-005 mem_ready  input  1  SHALL indicate memory is driving the instruction word onto data this cycle.
REQ-006 ir_ack  input  1  SHALL indicate that decode has consumed ir.
REQ-007 data  input  16  SHALL be the shared system bus, read-only to this block.
REQ-008 pc_out  output  1  SHALL enable the program counter onto the bus (zero-extended 8-bit address).
REQ-009 mar_load  output  1  SHALL load the memory address register from the bus.
REQ-010 mem_read  output  1  SHALL request a memory read and enable memory onto the bus.
REQ-011 pc_increment  output  1  SHALL advance the program counter by one at the next edge.
REQ-012 ir  output  16  SHALL hold the last fetched instruction word.
REQ-013 ir_valid  output  1  SHALL flag ir as new and unconsumed.
REQ-014 busy  output  1  SHALL be 1 whenever state is not IDLE.
REQ-015 fault  output  1  SHALL flag a memory-wait timeout.
REQ-016 fetch_count  output  8  SHALL count completed fetches.

Function
REQ-017 States SHALL be IDLE, ADDR, READ, HOLD, FAULT, one-hot or binary at implementer's choice.
REQ-018 IDLE: all strobes 0; start=1 at an edge -> ADDR; else stay.
REQ-019 ADDR: pc_out=1, mar_load=1 for exactly one cycle; unconditional -> READ.
REQ-020 READ: mem_read=1; pc_out=0; mar_load=0 (never two bus drivers in one cycle).
REQ-021 READ with mem_ready=1: pc_increment=1 combinationally that cycle; at the edge ir<=data, ir_valid<=1, fetch_count+1, -> HOLD.
REQ-022 pc_increment SHALL be 1 only in READ with mem_ready=1; never in any other state.
REQ-023 READ with mem_ready=0: 8-bit wait counter increments; counter cleared to 0 on every entry to READ.
REQ-024 READ with mem_ready=0 when wait counter equals WAIT_LIMIT-1: -> FAULT at that edge; ir, ir_valid, PC untouched.
REQ-025 HOLD: all strobes 0; ir_valid=1 and ir stable; ir_ack=1 at edge -> IDLE with ir_valid<=0; start ignored in HOLD.
REQ-026 FAULT: fault=1, all strobes 0, busy=1; exits only via rst.
REQ-027 Minimum latency: start sampled at edge N -> ADDR in cycle N+1, READ in N+2; mem_ready in N+2 -> ir_valid=1 from cycle N+3.
REQ-028 fetch_count SHALL wrap 255 -> 0 without flag.
REQ-029 ir_ack outside HOLD SHALL be ignored; mem_ready outside READ SHALL be ignored.
REQ-030 Strobes (pc_out, mar_load, mem_read) SHALL be registered-state decodes, glitch-free relative to state.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE from any state, including mid-READ and FAULT.
REQ-032 Reset values: ir=16'h0000, ir_valid=0, fault=0, fetch_count=0, wait counter=0; busy and all strobes 0 in the cycle after reset.
REQ-033 rst SHALL take priority over start, mem_ready, ir_ack in the same cycle.

Verification
REQ-034 Basic fetch: start=1 one cycle, mem_ready=1 in first READ cycle, data=16'h1234 -> pc_out/mar_load high 1 cycle, pc_increment 1 cycle, ir=16'h1234, ir_valid=1, fetch_count=1.
REQ-035 Wait states: mem_ready delayed 3 READ cycles, data=16'hABCD -> mem_read high 4 cycles, single pc_increment pulse, ir=16'hABCD, fault=0.
REQ-036 Timeout: WAIT_LIMIT=15, mem_ready never asserted -> FAULT after 15 READ cycles, fault=1, ir_valid=0, no pc_increment; start ignored until rst.
REQ-037 Backpressure: ir_ack withheld 10 cycles with start=1 held -> remains HOLD, ir stable, no strobes; ir_ack -> IDLE, next fetch begins following cycle.
REQ-038 Reset mid-READ: rst during wait -> IDLE next cycle, all outputs at reset values, next start fetches normally.
REQ-039 Wrap: 256 consecutive fetches -> fetch_count returns to 0, no other side effect.
